mem_stage_sram_ctrl: RTL and testbench

Parametrised memory-stage controller that replaces the single-cycle data memory with an external SRAM that needs wait states. It sits between the EXE/MEM pipeline register and the MEM/WB register. It translates ALU addresses to SRAM word addresses, sequences multi-cycle reads and writes, and drives a ready signal. The pipeline control uses ready to freeze all stages until the access completes.

---
 rtl/mem_stage_sram_ctrl_if.sv | 29 ++
 rtl/mem_stage_sram_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_ctrl_if.sv
// Bundle of the memory-stage signals: pipeline request/response plus the
// external SRAM pins, seen from the controller (slave) and its environment (master).
interface mem_stage_sram_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
);
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] st_val;
   logic              ready;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;
   logic              sram_we;
   logic              sram_oe;
   logic [15:0]       access_cnt;

   modport master (
      output wr_en, rd_en, alu_res, st_val, sram_rdata,
      input  ready, rd_data, sram_addr, sram_wdata, sram_we, sram_oe, access_cnt
   );

   modport slave (
      input  wr_en, rd_en, alu_res, st_val, sram_rdata,
      output ready, rd_data, sram_addr, sram_wdata, sram_we, sram_oe, access_cnt
   );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: maps ALU byte addresses onto a wait-stated SRAM and
// stalls the pipeline through ready until each read or write has completed.
module mem_stage_sram_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 16,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_STATES = 4
) (
   input logic                 clk,
   input logic                 rst,
   mem_stage_sram_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              op_wr_q, op_wr_d;
   logic              we_q, we_d;
   logic              oe_q, oe_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [15:0]       acc_cnt_q, acc_cnt_d;
   logic              req;
   logic              ready_c;
   logic              last_wait;

   // Byte address relative to the SRAM window, in words; the low two bits
   // drop out in the shift and out-of-window addresses simply wrap.
   function automatic logic [ADDR_W-1:0] map_addr(input logic [DATA_W-1:0] byte_addr);
      return ADDR_W'((byte_addr - DATA_W'(BASE_ADDR)) >> 2);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign req       = bus.rd_en | bus.wr_en;
   assign last_wait = (cnt_q == 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         op_wr_q   <= 1'b0;
         we_q      <= 1'b0;
         oe_q      <= 1'b0;
         rd_data_q <= '0;
         acc_cnt_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         op_wr_q   <= op_wr_d;
         we_q      <= we_d;
         oe_q      <= oe_d;
         rd_data_q <= rd_data_d;
         acc_cnt_q <= acc_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d = ACCESS;
               cnt_d   = CNT_LOAD;
            end
         end
         ACCESS: begin
            if (last_wait) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         // Inputs still show the finished instruction here, so no re-sample.
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      ready_c   = 1'b1;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      op_wr_d   = op_wr_q;
      we_d      = we_q;
      oe_d      = oe_q;
      rd_data_d = rd_data_q;
      acc_cnt_d = acc_cnt_q;
      unique case (state_q)
         IDLE: begin
            ready_c = ~req;
            if (req) begin
               addr_d  = map_addr(bus.alu_res);
               wdata_d = bus.st_val;
               op_wr_d = bus.wr_en;
               we_d    = bus.wr_en;
               oe_d    = ~bus.wr_en;
            end
         end
         ACCESS: begin
            ready_c = 1'b0;
            if (last_wait) begin
               we_d      = 1'b0;
               oe_d      = 1'b0;
               acc_cnt_d = sat_inc(acc_cnt_q);
               if (!op_wr_q) begin
                  rd_data_d = bus.sram_rdata;
               end
            end
         end
         DONE: begin
            ready_c = 1'b1;
         end
         default: begin
            ready_c = 1'b1;
            we_d    = 1'b0;
            oe_d    = 1'b0;
         end
      endcase
   end

   assign bus.ready      = ready_c;
   assign bus.rd_data    = rd_data_q;
   assign bus.sram_addr  = addr_q;
   assign bus.sram_wdata = wdata_q;
   assign bus.sram_we    = we_q;
   assign bus.sram_oe    = oe_q;
   assign bus.access_cnt = acc_cnt_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed and randomized bench for mem_stage_sram_ctrl with an SRAM model and
// a transaction-level reference of memory contents, load results and counts.
module tb_mem_stage_sram_ctrl;

   localparam int WS = 4;

   logic clk;
   logic rst;

   mem_stage_sram_ctrl_if #(.DATA_W(32), .ADDR_W(16)) bus ();

   mem_stage_sram_ctrl #(
      .DATA_W(32), .ADDR_W(16), .BASE_ADDR(1024), .WAIT_STATES(WS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: asynchronous read, write on each edge the strobe is high.
   bit [31:0]   mem [0:65535];
   logic        preload_en;
   logic [15:0] preload_a;
   logic [31:0] preload_d;

   always @(posedge clk) begin
      if (preload_en) mem[preload_a] <= preload_d;
      else if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
   end
   assign bus.sram_rdata = mem[bus.sram_addr];

   bit [31:0] ref_mem [0:65535];
   logic [31:0] ref_rd;
   logic [15:0] ref_cnt;
   int n_cmp;
   int n_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] word_of(input logic [31:0] a);
      return 16'(((a - 32'd1024) / 32'd4) % 32'd65536);
   endfunction

   task automatic preload(input logic [15:0] w, input logic [31:0] v);
      @(negedge clk);
      preload_en = 1'b1;
      preload_a  = w;
      preload_d  = v;
      ref_mem[w] = v;
   endtask

   // One complete access as the pipeline sees it, checked cycle by cycle.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] v);
      logic [15:0] w;
      w = word_of(a);
      @(negedge clk);
      bus.rd_en   = rd;
      bus.wr_en   = wr;
      bus.alu_res = a;
      bus.st_val  = v;
      #1 chk("idle_ready", 32'(bus.ready), 32'd0);
      for (int i = 0; i < WS; i++) begin
         @(negedge clk);
         chk("acc_ready", 32'(bus.ready), 32'd0);
         chk("acc_addr", 32'(bus.sram_addr), 32'(w));
         chk("acc_we", 32'(bus.sram_we), 32'(wr));
         chk("acc_oe", 32'(bus.sram_oe), 32'(!wr));
         if (wr) chk("acc_wdata", bus.sram_wdata, v);
      end
      if (wr) ref_mem[w] = v;
      else    ref_rd = ref_mem[w];
      if (ref_cnt != 16'hFFFF) ref_cnt++;
      @(negedge clk);
      chk("done_ready", 32'(bus.ready), 32'd1);
      chk("done_rd_data", bus.rd_data, ref_rd);
      chk("done_cnt", 32'(bus.access_cnt), 32'(ref_cnt));
      chk("done_we", 32'(bus.sram_we), 32'd0);
      chk("done_oe", 32'(bus.sram_oe), 32'd0);
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      ref_rd = 32'd0;
      ref_cnt = 16'd0;
      rst = 1'b1;
      preload_en = 1'b0;
      preload_a = 16'd0;
      preload_d = 32'd0;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.alu_res = 32'd0;
      bus.st_val = 32'd0;

      preload(16'd0, 32'hDEADBEEF);
      preload(16'd2, $urandom);
      preload(16'hFF00, $urandom);
      for (int i = 8; i < 256; i++) preload(16'(i), $urandom);
      @(negedge clk);
      preload_en = 1'b0;

      @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_rd_data", bus.rd_data, 32'd0);
      chk("rst_addr", 32'(bus.sram_addr), 32'd0);
      chk("rst_wdata", bus.sram_wdata, 32'd0);
      chk("rst_we", 32'(bus.sram_we), 32'd0);
      chk("rst_oe", 32'(bus.sram_oe), 32'd0);
      chk("rst_cnt", 32'(bus.access_cnt), 32'd0);
      rst = 1'b0;

      do_access(1'b1, 1'b0, 32'd1024, 32'd0);
      chk("t1_value", bus.rd_data, 32'hDEADBEEF);
      do_access(1'b0, 1'b1, 32'd1036, 32'h12345678);
      do_access(1'b1, 1'b0, 32'd1036, 32'd0);
      chk("t2_readback", bus.rd_data, 32'h12345678);
      do_access(1'b1, 1'b1, 32'd1028, 32'hA5A5_0F0F);
      chk("t3_rd_kept", bus.rd_data, 32'h12345678);
      do_access(1'b1, 1'b0, 32'd1028, 32'd0);
      chk("t3_readback", bus.rd_data, 32'hA5A5_0F0F);

      // Reset on the second ACCESS cycle of a write to word 5.
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.alu_res = 32'd1044;
      bus.st_val = 32'hCAFE_F00D;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      bus.wr_en = 1'b0;
      @(negedge clk);
      chk("t5_ready", 32'(bus.ready), 32'd1);
      chk("t5_we", 32'(bus.sram_we), 32'd0);
      chk("t5_cnt", 32'(bus.access_cnt), 32'd0);
      chk("t5_rd_data", bus.rd_data, 32'd0);
      rst = 1'b0;
      ref_cnt = 16'd0;
      ref_rd = 32'd0;

      do_access(1'b1, 1'b0, 32'd1024, 32'd0);
      do_access(1'b1, 1'b0, 32'd1032, 32'd0);
      chk("t4_cnt", 32'(bus.access_cnt), 32'd2);
      chk("t4_word2", bus.rd_data, ref_mem[2]);

      do_access(1'b1, 1'b0, 32'd0, 32'd0);
      chk("t6_wrap_data", bus.rd_data, ref_mem[16'hFF00]);
      do_access(1'b1, 1'b0, 32'd1026, 32'd0);
      chk("t6_misalign", bus.rd_data, 32'hDEADBEEF);

      for (int n = 0; n < 40; n++) begin
         int unsigned op;
         logic [31:0] a;
         op = $urandom_range(0, 2);
         a = 32'd1024 + 32'($urandom_range(8, 255)) * 32'd4 + 32'($urandom_range(0, 3));
         do_access(op != 1, op != 0, a, $urandom);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("gap_ready", 32'(bus.ready), 32'd1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
